// File: rtl/regfile_scoreboard_if.sv
// Writeback, read-port and issue signals between the pipeline and the
// register file / pending-write scoreboard.
interface regfile_scoreboard_if #(
    parameter int NUM_REGS  = 32,
    parameter int DATA_SIZE = 32
);
    localparam int AW = $clog2(NUM_REGS);

    logic                 i_wb_regwrite;
    logic [AW-1:0]        i_wb_rdest;
    logic [DATA_SIZE-1:0] i_wb_result;

    logic [AW-1:0]        i_rs1_addr;
    logic [AW-1:0]        i_rs2_addr;
    logic [DATA_SIZE-1:0] o_rs1_data;
    logic [DATA_SIZE-1:0] o_rs2_data;

    logic                 i_issue_valid;
    logic                 i_issue_rs1_en;
    logic                 i_issue_rs2_en;
    logic                 i_issue_regwrite;
    logic [AW-1:0]        i_issue_rdest;
    logic                 o_issue_ready;
    logic                 o_hazard;

    logic                 i_flush;
    logic                 o_busy;
    logic                 o_err_underflow;

    // Pipeline side: drives writeback, read addresses and issue requests.
    modport master (
        output i_wb_regwrite, i_wb_rdest, i_wb_result,
        output i_rs1_addr, i_rs2_addr,
        input  o_rs1_data, o_rs2_data,
        output i_issue_valid, i_issue_rs1_en, i_issue_rs2_en,
        output i_issue_regwrite, i_issue_rdest,
        input  o_issue_ready, o_hazard,
        output i_flush,
        input  o_busy, o_err_underflow
    );

    // Register file / scoreboard side.
    modport slave (
        input  i_wb_regwrite, i_wb_rdest, i_wb_result,
        input  i_rs1_addr, i_rs2_addr,
        output o_rs1_data, o_rs2_data,
        input  i_issue_valid, i_issue_rs1_en, i_issue_rs2_en,
        input  i_issue_regwrite, i_issue_rdest,
        output o_issue_ready, o_hazard,
        input  i_flush,
        output o_busy, o_err_underflow
    );
endinterface

// File: rtl/regfile_scoreboard.sv
// Integer register file with bypassing read ports and a per-register
// pending-write scoreboard that raises RAW hazards toward issue logic.
module regfile_scoreboard #(
    parameter int NUM_REGS  = 32,
    parameter int DATA_SIZE = 32,
    parameter int PEND_W    = 2
) (
    input  logic                 i_aclk,
    input  logic                 i_sreset,
    regfile_scoreboard_if.slave  bus
);
    localparam int AW = $clog2(NUM_REGS);
    localparam logic [PEND_W-1:0] PEND_MAX = '1;

    logic [DATA_SIZE-1:0] rf   [NUM_REGS];
    logic [PEND_W-1:0]    pend [NUM_REGS];
    logic [PEND_W-1:0]    eff  [NUM_REGS];
    logic                 err_underflow;

    logic [NUM_REGS-1:0]  inc_vec;
    logic [NUM_REGS-1:0]  dec_vec;
    logic                 wb_hit;
    logic                 issue_inc;
    logic                 rs1_haz;
    logic                 rs2_haz;
    logic                 rd_sat;
    logic                 hazard;
    logic                 ready;
    logic                 busy;
    logic [DATA_SIZE-1:0] rs1_data;
    logic [DATA_SIZE-1:0] rs2_data;

    assign wb_hit = bus.i_wb_regwrite && (bus.i_wb_rdest != '0);

    // Read ports: x0 reads zero, a same-cycle writeback is forwarded.
    always_comb begin
        rs1_data = rf[bus.i_rs1_addr];
        if (bus.i_rs1_addr == '0)
            rs1_data = '0;
        else if (wb_hit && (bus.i_wb_rdest == bus.i_rs1_addr))
            rs1_data = bus.i_wb_result;
    end

    always_comb begin
        rs2_data = rf[bus.i_rs2_addr];
        if (bus.i_rs2_addr == '0)
            rs2_data = '0;
        else if (wb_hit && (bus.i_wb_rdest == bus.i_rs2_addr))
            rs2_data = bus.i_wb_result;
    end

    // Effective count discounts the write retiring this cycle, so a source
    // satisfied by the bypass does not stall.
    always_comb begin
        for (int r = 0; r < NUM_REGS; r++) begin
            dec_vec[r] = wb_hit && (bus.i_wb_rdest == AW'(r)) && (pend[r] != '0);
            eff[r]     = pend[r] - PEND_W'(dec_vec[r]);
        end
    end

    assign rs1_haz = bus.i_issue_rs1_en && (bus.i_rs1_addr != '0) &&
                     (eff[bus.i_rs1_addr] != '0);
    assign rs2_haz = bus.i_issue_rs2_en && (bus.i_rs2_addr != '0) &&
                     (eff[bus.i_rs2_addr] != '0);
    assign hazard  = rs1_haz || rs2_haz;

    // A saturated destination counter stalls issue rather than wrapping.
    assign rd_sat    = bus.i_issue_regwrite && (bus.i_issue_rdest != '0) &&
                       (eff[bus.i_issue_rdest] == PEND_MAX);
    assign ready     = !hazard && !rd_sat;
    assign issue_inc = bus.i_issue_valid && ready && bus.i_issue_regwrite &&
                       (bus.i_issue_rdest != '0);

    always_comb begin
        for (int r = 0; r < NUM_REGS; r++)
            inc_vec[r] = issue_inc && (bus.i_issue_rdest == AW'(r));
    end

    always_comb begin
        busy = 1'b0;
        for (int r = 0; r < NUM_REGS; r++)
            busy = busy || (pend[r] != '0);
    end

    // NOTE: all sequential state uses non-blocking assignments so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge i_aclk) begin
        if (i_sreset) begin
            // NOTE: the register array is cleared too, so reads after reset
            // return zero instead of whatever the storage powered up with.
            for (int r = 0; r < NUM_REGS; r++) begin
                rf[r]   <= '0;
                pend[r] <= '0;
            end
            err_underflow <= 1'b0;
        end else begin
            if (wb_hit)
                rf[bus.i_wb_rdest] <= bus.i_wb_result;

            for (int r = 0; r < NUM_REGS; r++) begin
                if (bus.i_flush)
                    pend[r] <= '0;
                else if (inc_vec[r] && !dec_vec[r])
                    pend[r] <= pend[r] + PEND_W'(1);
                else if (dec_vec[r] && !inc_vec[r])
                    pend[r] <= pend[r] - PEND_W'(1);
            end

            if (!bus.i_flush && wb_hit && (pend[bus.i_wb_rdest] == '0))
                err_underflow <= 1'b1;
        end
    end

    assign bus.o_rs1_data      = rs1_data;
    assign bus.o_rs2_data      = rs2_data;
    assign bus.o_hazard        = hazard;
    assign bus.o_issue_ready   = ready;
    assign bus.o_busy          = busy;
    assign bus.o_err_underflow = err_underflow;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Bench for regfile_scoreboard: directed vector table, hand sequences for
// flush/reset/underflow, then random traffic against a reference model.
module tb_regfile_scoreboard;
    localparam int NR = 32;
    localparam int DW = 32;
    localparam int PW = 2;
    localparam int PMAX = (1 << PW) - 1;

    logic i_aclk;
    logic i_sreset;

    regfile_scoreboard_if #(.NUM_REGS(NR), .DATA_SIZE(DW)) bus ();

    regfile_scoreboard #(.NUM_REGS(NR), .DATA_SIZE(DW), .PEND_W(PW)) dut (
        .i_aclk   (i_aclk),
        .i_sreset (i_sreset),
        .bus      (bus)
    );

    initial i_aclk = 1'b0;
    always #5 i_aclk = ~i_aclk;

    typedef struct {
        logic        rst;
        logic        we;
        logic [4:0]  wrd;
        logic [31:0] wres;
        logic [4:0]  a1;
        logic [4:0]  a2;
        logic        v;
        logic        e1;
        logic        e2;
        logic        iw;
        logic [4:0]  ird;
        logic        fl;
    } stim_t;

    typedef struct {
        stim_t       s;
        logic [31:0] x1;
        logic [31:0] x2;
        logic        haz;
        logic        rdy;
        logic        busy;
        logic        err;
    } vec_t;

    int total = 0;
    int bad   = 0;

    // Reference model state: plain counts and values per register.
    int          m_pend [NR];
    logic [31:0] m_rf   [NR];
    bit          m_err;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic stim_t st(logic we, logic [4:0] wrd, logic [31:0] wres,
                                 logic [4:0] a1, logic [4:0] a2, logic v,
                                 logic e1, logic e2, logic iw, logic [4:0] ird);
        stim_t s;
        s.rst = 1'b0; s.fl = 1'b0;
        s.we = we; s.wrd = wrd; s.wres = wres; s.a1 = a1; s.a2 = a2;
        s.v = v; s.e1 = e1; s.e2 = e2; s.iw = iw; s.ird = ird;
        return s;
    endfunction

    task automatic apply(input stim_t s);
        i_sreset             = s.rst;
        bus.i_wb_regwrite    = s.we;
        bus.i_wb_rdest       = s.wrd;
        bus.i_wb_result      = s.wres;
        bus.i_rs1_addr       = s.a1;
        bus.i_rs2_addr       = s.a2;
        bus.i_issue_valid    = s.v;
        bus.i_issue_rs1_en   = s.e1;
        bus.i_issue_rs2_en   = s.e2;
        bus.i_issue_regwrite = s.iw;
        bus.i_issue_rdest    = s.ird;
        bus.i_flush          = s.fl;
    endtask

    function automatic logic [31:0] m_read(int a);
        if (a == 0) return 32'h0;
        if (bus.i_wb_regwrite && int'(bus.i_wb_rdest) == a) return bus.i_wb_result;
        return m_rf[a];
    endfunction

    function automatic int m_eff(int r);
        if (r != 0 && bus.i_wb_regwrite && int'(bus.i_wb_rdest) == r && m_pend[r] > 0)
            return m_pend[r] - 1;
        return m_pend[r];
    endfunction

    function automatic bit m_hazard();
        int a1 = int'(bus.i_rs1_addr);
        int a2 = int'(bus.i_rs2_addr);
        return (bus.i_issue_rs1_en && a1 != 0 && m_eff(a1) != 0) ||
               (bus.i_issue_rs2_en && a2 != 0 && m_eff(a2) != 0);
    endfunction

    function automatic bit m_ready();
        int rd = int'(bus.i_issue_rdest);
        return !m_hazard() && !(bus.i_issue_regwrite && rd != 0 && m_eff(rd) == PMAX);
    endfunction

    function automatic bit m_busy();
        for (int r = 0; r < NR; r++) if (m_pend[r] != 0) return 1'b1;
        return 1'b0;
    endfunction

    // Advance the model by one clock using the inputs presented at the edge.
    task automatic model_step();
        int wrd = int'(bus.i_wb_rdest);
        int ird = int'(bus.i_issue_rdest);
        bit acc = bus.i_issue_valid && m_ready() && bus.i_issue_regwrite && ird != 0;
        if (i_sreset) begin
            for (int r = 0; r < NR; r++) begin m_pend[r] = 0; m_rf[r] = 32'h0; end
            m_err = 1'b0;
        end else begin
            if (bus.i_wb_regwrite && wrd != 0) m_rf[wrd] = bus.i_wb_result;
            if (bus.i_flush) begin
                for (int r = 0; r < NR; r++) m_pend[r] = 0;
            end else begin
                if (bus.i_wb_regwrite && wrd != 0) begin
                    if (m_pend[wrd] > 0) m_pend[wrd]--;
                    else m_err = 1'b1;
                end
                if (acc) m_pend[ird]++;
            end
        end
    endtask

    task automatic settle();
        @(negedge i_aclk);
    endtask

    task automatic tick();
        @(posedge i_aclk);
        model_step();
        #1;
    endtask

    task automatic check_model();
        check("rand_rs1", bus.o_rs1_data, m_read(int'(bus.i_rs1_addr)));
        check("rand_rs2", bus.o_rs2_data, m_read(int'(bus.i_rs2_addr)));
        check("rand_hazard", 32'(bus.o_hazard), 32'(m_hazard()));
        check("rand_ready", 32'(bus.o_issue_ready), 32'(m_ready()));
        check("rand_busy", 32'(bus.o_busy), 32'(m_busy()));
        check("rand_err", 32'(bus.o_err_underflow), 32'(m_err));
    endtask

    vec_t  vecs [16];
    stim_t idle;
    stim_t s;

    initial begin
        idle = st(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        // Bypass, x0, RAW hazard, saturation and same-cycle inc/dec.
        vecs[0]  = '{st(1, 5, 32'hDEADBEEF, 5, 0, 0, 0, 0, 0, 0), 32'hDEADBEEF, 0,     0, 1, 0, 0};
        vecs[1]  = '{st(0, 0, 0,            5, 0, 0, 0, 0, 0, 0), 32'hDEADBEEF, 0,     0, 1, 0, 1};
        vecs[2]  = '{st(1, 0, 32'h1234,     5, 0, 0, 0, 0, 0, 0), 32'hDEADBEEF, 0,     0, 1, 0, 1};
        vecs[3]  = '{st(0, 0, 0,            5, 0, 0, 0, 0, 0, 0), 32'hDEADBEEF, 0,     0, 1, 0, 1};
        vecs[4]  = '{st(0, 0, 0,            0, 0, 1, 0, 0, 1, 7), 0,            0,     0, 1, 0, 1};
        vecs[5]  = '{st(0, 0, 0,            7, 0, 1, 1, 0, 0, 0), 0,            0,     1, 0, 1, 1};
        vecs[6]  = '{st(1, 7, 32'h55,       7, 0, 1, 1, 0, 0, 0), 32'h55,       0,     0, 1, 1, 1};
        vecs[7]  = '{st(0, 0, 0,            7, 0, 0, 0, 0, 0, 0), 32'h55,       0,     0, 1, 0, 1};
        vecs[8]  = '{st(0, 0, 0,            0, 0, 1, 0, 0, 1, 3), 0,            0,     0, 1, 0, 1};
        vecs[9]  = '{st(0, 0, 0,            0, 0, 1, 0, 0, 1, 3), 0,            0,     0, 1, 1, 1};
        vecs[10] = '{st(0, 0, 0,            0, 0, 1, 0, 0, 1, 3), 0,            0,     0, 1, 1, 1};
        vecs[11] = '{st(0, 0, 0,            0, 0, 1, 0, 0, 1, 3), 0,            0,     0, 0, 1, 1};
        vecs[12] = '{st(1, 3, 32'hAA,       3, 0, 1, 0, 0, 1, 3), 32'hAA,       0,     0, 1, 1, 1};
        vecs[13] = '{st(0, 0, 0,            3, 0, 1, 0, 0, 1, 3), 32'hAA,       0,     0, 0, 1, 1};
        vecs[14] = '{st(0, 0, 0,            0, 3, 1, 0, 1, 0, 0), 0,            32'hAA, 1, 0, 1, 1};
        vecs[15] = '{st(1, 3, 32'hBB,       0, 3, 1, 0, 1, 0, 0), 0,            32'hBB, 1, 0, 1, 1};

        apply(idle);
        i_sreset = 1'b1;
        tick(); tick();
        i_sreset = 1'b0;

        for (int i = 0; i < 16; i++) begin
            apply(vecs[i].s);
            settle();
            check($sformatf("vec%0d_rs1", i), bus.o_rs1_data, vecs[i].x1);
            check($sformatf("vec%0d_rs2", i), bus.o_rs2_data, vecs[i].x2);
            check($sformatf("vec%0d_hazard", i), 32'(bus.o_hazard), 32'(vecs[i].haz));
            check($sformatf("vec%0d_ready", i), 32'(bus.o_issue_ready), 32'(vecs[i].rdy));
            check($sformatf("vec%0d_busy", i), 32'(bus.o_busy), 32'(vecs[i].busy));
            check($sformatf("vec%0d_err", i), 32'(bus.o_err_underflow), 32'(vecs[i].err));
            tick();
        end

        // Reset with writeback and issue presented: both must be dropped.
        s = st(1, 9, 32'hFFFF, 0, 0, 1, 0, 0, 1, 9);
        s.rst = 1'b1;
        apply(s);
        tick();
        for (int r = 1; r < NR; r++) begin
            apply(st(0, 0, 0, 5'(r), 5'(NR - r), 0, 0, 0, 0, 0));
            settle();
            check($sformatf("rst_rd_x%0d", r), bus.o_rs1_data, 32'h0);
            check($sformatf("rst_rd_x%0d_p2", NR - r), bus.o_rs2_data, 32'h0);
            tick();
        end
        settle();
        check("rst_ready", 32'(bus.o_issue_ready), 32'h1);
        check("rst_busy", 32'(bus.o_busy), 32'h0);
        check("rst_hazard", 32'(bus.o_hazard), 32'h0);
        check("rst_err", 32'(bus.o_err_underflow), 32'h0);

        // Two in-flight writes to x9, then flush.
        apply(st(0, 0, 0, 0, 0, 1, 0, 0, 1, 9)); tick();
        apply(st(0, 0, 0, 0, 0, 1, 0, 0, 1, 9)); tick();
        apply(st(0, 0, 0, 9, 0, 0, 1, 0, 0, 0));
        settle();
        check("pend9_busy", 32'(bus.o_busy), 32'h1);
        check("pend9_hazard", 32'(bus.o_hazard), 32'h1);
        s = st(1, 4, 32'h44, 0, 0, 1, 0, 0, 1, 9);
        s.fl = 1'b1;
        apply(s); tick();
        apply(st(0, 0, 0, 9, 4, 0, 1, 0, 0, 0));
        settle();
        check("flush_busy", 32'(bus.o_busy), 32'h0);
        check("flush_hazard", 32'(bus.o_hazard), 32'h0);
        check("flush_no_underflow", 32'(bus.o_err_underflow), 32'h0);
        check("flush_rf_write", bus.o_rs2_data, 32'h44);
        tick();

        // Writeback with no pending write sets the sticky error.
        apply(st(1, 9, 32'h77, 0, 0, 0, 0, 0, 0, 0));
        settle();
        check("uflow_pre_err", 32'(bus.o_err_underflow), 32'h0);
        tick();
        apply(st(0, 0, 0, 9, 0, 1, 0, 0, 1, 12));
        settle();
        check("uflow_err", 32'(bus.o_err_underflow), 32'h1);
        check("uflow_rf9", bus.o_rs1_data, 32'h77);
        tick();

        // Mid-stream reset clears rf, counters and error.
        s = st(1, 9, 32'h99, 9, 0, 0, 0, 0, 0, 0);
        s.rst = 1'b1;
        apply(s);
        settle();
        check("prerst_busy", 32'(bus.o_busy), 32'h1);
        tick();
        apply(st(0, 0, 0, 9, 12, 0, 0, 0, 0, 0));
        settle();
        check("midrst_rf9", bus.o_rs1_data, 32'h0);
        check("midrst_err", 32'(bus.o_err_underflow), 32'h0);
        check("midrst_busy", 32'(bus.o_busy), 32'h0);
        check("midrst_ready", 32'(bus.o_issue_ready), 32'h1);
        tick();

        // Random traffic on a small register window to force collisions.
        for (int c = 0; c < 3000; c++) begin
            s.rst  = ($urandom_range(0, 99) == 0);
            s.fl   = ($urandom_range(0, 15) == 0);
            s.we   = 1'($urandom_range(0, 1));
            s.wrd  = 5'($urandom_range(0, 7));
            s.wres = $urandom;
            s.a1   = 5'($urandom_range(0, 7));
            s.a2   = 5'($urandom_range(0, 7));
            s.v    = ($urandom_range(0, 3) != 0);
            s.e1   = 1'($urandom_range(0, 1));
            s.e2   = 1'($urandom_range(0, 1));
            s.iw   = ($urandom_range(0, 3) != 0);
            s.ird  = 5'($urandom_range(0, 7));
            apply(s);
            settle();
            check_model();
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
